// File: rtl/line_reorder_buffer.sv
// Ping-pong line buffer: stores pixels at their mirrored x and replays each completed line in raster order.
// Optional duplicate-x detection per line is built only when LRB_DUP_CHECK_EN is defined.
module line_reorder_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] pixel_i,
  input  logic [ADDR_WIDTH-1:0] x_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic [ADDR_WIDTH-1:0] x_o,
  output logic                  valid_o,
  output logic                  line_start_o,
  output logic                  overrun_o,
  output logic                  err_dup_o
);

  localparam int                    IDX_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_WIDTH:0]   LINE_LEN = (ADDR_WIDTH+1)'(IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_X   = ADDR_WIDTH'(IMG_WIDTH - 1);

  // state  | meaning
  // S_IDLE | nothing being replayed; start when the next bank in fill order is full
  // S_READ | issuing one read address per cycle from bank rd_sel_q
  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem_q [2][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  state_t                state_q, state_d;
  logic                  wr_sel_q, wr_sel_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [1:0]            full_q, full_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] rd_x_q, rd_x_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_ls_q, out_ls_d;
  logic [DATA_WIDTH-1:0] out_pix_q, out_pix_d;
  logic [ADDR_WIDTH-1:0] out_x_q, out_x_d;

  logic                  in_range, wr_accept, wr_done;
  logic                  rd_start, rd_en, rd_release;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign in_range  = ({1'b0, x_i} < LINE_LEN);
  assign wr_accept = valid_i && in_range && !full_q[wr_sel_q];
  assign wr_done   = wr_accept && ((wr_cnt_q + 1'b1) == LINE_LEN);
  assign wr_idx    = x_i[IDX_W-1:0];
  assign rd_idx    = iss_addr[IDX_W-1:0];

  // Banks fill and drain in the same alternating order, so rd_sel_q always names the oldest full bank.
  assign rd_start  = (state_q == S_IDLE) && full_q[rd_sel_q];

  always_comb begin
    wr_sel_d  = wr_sel_q;
    wr_cnt_d  = wr_cnt_q;
    overrun_d = overrun_q;
    if (valid_i && !wr_accept) begin
      overrun_d = 1'b1;
    end
    if (wr_done) begin
      wr_sel_d = ~wr_sel_q;
      wr_cnt_d = '0;
    end else if (wr_accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    rd_addr_d  = rd_addr_q;
    rd_en      = 1'b0;
    rd_release = 1'b0;
    iss_addr   = '0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          rd_en     = 1'b1;
          iss_addr  = '0;
          rd_addr_d = ADDR_WIDTH'(1);
          state_d   = S_READ;
        end
      end
      S_READ: begin
        rd_en     = 1'b1;
        iss_addr  = rd_addr_q;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_X) begin
          rd_release = 1'b1;
          rd_sel_d   = ~rd_sel_q;
          rd_addr_d  = '0;
          if (!full_q[~rd_sel_q]) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Release and fill completion always target opposite banks, so both may apply in one cycle.
  always_comb begin
    full_d = full_q;
    if (rd_release) begin
      full_d[rd_sel_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_sel_q] = 1'b1;
    end
  end

  always_comb begin
    rd_vld_d  = rd_en;
    rd_x_d    = rd_en ? iss_addr : rd_x_q;
    out_vld_d = rd_vld_q;
    out_ls_d  = rd_vld_q && (rd_x_q == '0);
    out_pix_d = out_pix_q;
    out_x_d   = out_x_q;
    if (rd_vld_q) begin
      out_pix_d = rd_data_q;
      out_x_d   = rd_x_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_sel_q][wr_idx] <= pixel_i;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_sel_q][rd_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wr_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= '0;
      rd_sel_q  <= 1'b0;
      rd_addr_q <= '0;
      overrun_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_x_q    <= '0;
      out_vld_q <= 1'b0;
      out_ls_q  <= 1'b0;
      out_pix_q <= '0;
      out_x_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      rd_sel_q  <= rd_sel_d;
      rd_addr_q <= rd_addr_d;
      overrun_q <= overrun_d;
      rd_vld_q  <= rd_vld_d;
      rd_x_q    <= rd_x_d;
      out_vld_q <= out_vld_d;
      out_ls_q  <= out_ls_d;
      out_pix_q <= out_pix_d;
      out_x_q   <= out_x_d;
    end
  end

`ifdef LRB_DUP_CHECK_EN
  logic [IMG_WIDTH-1:0] map_q [2];
  logic [IMG_WIDTH-1:0] map_d [2];
  logic                 err_dup_q, err_dup_d;

  // The map of the bank about to become the write bank is wiped as the current line completes.
  always_comb begin
    map_d     = map_q;
    err_dup_d = err_dup_q;
    if (wr_accept) begin
      if (map_q[wr_sel_q][wr_idx]) begin
        err_dup_d = 1'b1;
      end
      map_d[wr_sel_q][wr_idx] = 1'b1;
    end
    if (wr_done) begin
      map_d[~wr_sel_q] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q[0]  <= '0;
      map_q[1]  <= '0;
      err_dup_q <= 1'b0;
    end else begin
      map_q     <= map_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign err_dup_o = err_dup_q;
`else
  assign err_dup_o = 1'b0;
`endif

  assign pixel_o      = out_pix_q;
  assign x_o          = out_x_q;
  assign valid_o      = out_vld_q;
  assign line_start_o = out_ls_q;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/line_reorder_buffer.md
# line_reorder_buffer

Ping-pong line buffer placed directly downstream of the horizontal mirror stage. It consumes (pixel, mirrored x) pairs, writes each pixel into line RAM at address x, and replays each completed line in ascending x order. The result is a raster-ordered mirrored stream for the display/output stages. Input rate is at most one pixel per clock; output streams one pixel per clock once a line is complete.

## Interface
- DATA_WIDTH, 8, pixel bit width
- IMG_WIDTH, 640, pixels per line (≤ 1024)
- ADDR_WIDTH, 10, RAM address / x width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- pixel_in  in  DATA_WIDTH  input pixel
- x_in  in  ADDR_WIDTH  write address (mirrored x) for pixel_in
- valid_in  in  1  pixel_in/x_in qualifier
- pixel_out  out  DATA_WIDTH  reordered pixel
- x_out  out  ADDR_WIDTH  raster x of pixel_out, 0..IMG_WIDTH-1
- valid_out  out  1  pixel_out/x_out qualifier
- line_start  out  1  high with valid_out when x_out == 0
- overrun  out  1  sticky: a pixel was dropped
- err_dup  out  1  sticky: duplicate x within one line (see Configuration)

## Operation
- Storage: two banks, each IMG_WIDTH × DATA_WIDTH, with a synchronous read. Contents are not reset.
- Write side:
  - wr_sel selects the bank being filled; wr_cnt counts accepted writes.
  - On valid_in, with x_in < IMG_WIDTH and bank wr_sel not full: write bank[wr_sel][x_in] and increment wr_cnt.
  - When wr_cnt reaches IMG_WIDTH: set full[wr_sel], toggle wr_sel, clear wr_cnt.
- Drop rules (pixel discarded, wr_cnt unchanged, overrun ← 1):
  - x_in ≥ IMG_WIDTH.
  - Bank wr_sel is still full, i.e. not yet released by the reader.
- Read FSM:
  - IDLE: if any bank is full, choose it (priority to the bank filled first, tracked by rd_sel = oldest). Issue read address 0, go to READ.
  - READ: issue rd_addr+1 each cycle. When issuing address IMG_WIDTH-1, clear full[rd_sel] (bank released).
    - If the other bank is full in that same cycle, switch rd_sel and continue at address 0 next cycle with no gap.
    - Otherwise return to IDLE.
- Output register: one cycle after each address issue, register valid_out=1, pixel_out=RAM data, x_out=address, and line_start=(address==0). Otherwise valid_out=0, and pixel_out/x_out hold.
- Simultaneous release and fill completion on opposite banks: both take effect; there is no conflict.
- Write into a bank on the cycle after its release is legal; the released bank's last read was already issued.
- Reset mid-line: all counters, full flags, wr_sel/rd_sel, FSM (→ IDLE) and outputs clear. A partially written or partially read line is discarded with no output.

## Timing
- Reset values: pixel_out 0, x_out 0, valid_out 0, line_start 0, overrun 0, err_dup 0.
- Latency: the last pixel of a line is sampled at edge T. full is set at T, read address 0 is issued at T+1, and the first valid_out is registered at T+2.
- Each line yields exactly IMG_WIDTH consecutive valid_out cycles.
- At one input pixel per cycle the output is continuous across lines, and overrun never sets.
- Line ordering of the output equals the order in which lines completed.
- overrun and err_dup clear only on rst.

## Configuration
- LRB_DUP_CHECK_EN:
  - **Defined:** each bank carries an IMG_WIDTH-bit written map, cleared when that bank becomes the write bank.
    - An accepted write to an already-marked location sets err_dup.
    - The write still occurs and still counts.
  - **Undefined:** no map is built, and err_dup is tied to 0.

## Test plan
- **Reversed line:** IMG_WIDTH=8, feed x_in 7..0 with pixels 0..7 on consecutive cycles → valid_out 8 cycles starting 2 edges after the last input, x_out 0..7, pixel_out 7..0, line_start only at x_out=0.
- **Back-to-back lines:** three lines streamed continuously → 24 contiguous valid_out cycles, lines in input order, overrun=0.
- **Sparse input:** valid_in every 3rd cycle → each line is emitted only after its 8th write, with identical data.
- **Out of range:** x_in=8 with valid_in → pixel dropped, overrun=1, line completes only after 8 legal writes.
- **Overrun:** reader stalled via two full banks (IMG_WIDTH=8, burst input while bank 0 is still being read, force) → extra pixels dropped, overrun=1, emitted lines uncorrupted.
- **Reset mid-read, then duplicates:**
  - rst at the 4th output pixel → valid_out=0 next edge, then no output until a fresh 8-pixel line.
  - With LRB_DUP_CHECK_EN, x_in=3 written twice → err_dup=1.
